// File: rtl/id_ex_pipe_reg_if.sv
// ---------------------------------------------------------------------------
// id_ex_pipe_reg_if
// Bundle between the decode stage / hazard unit and the ID/EX pipeline
// register, plus the registered view presented to the execute stage.
//
// Signals:
//   stall_i, flush_i          hazard unit controls (hold / insert bubble)
//   valid_i                   ID stage holds a real instruction
//   pc4_i, rs_data_i,
//   rt_data_i, imm_i          DATA_W-wide decode data
//   rs_i, rt_i, rd_i          REG_AW-wide register addresses
//   shamt_i, funct_i          instruction fields [10:6], [5:0]
//   reg_write_i .. reg_dst_i  single-bit decoder controls
//   alu_op_i                  ALUOP_W-wide decoder ALU op
//   *_o                       registered copies presented to EX
//   bubble_cnt_o, stall_cnt_o 32-bit perf counters (ID_EX_PERF_CNT_EN only)
//
// Modports: master = decode/hazard side, slave = pipeline register.
// Optional macro: ID_EX_PERF_CNT_EN adds the two counter outputs.
// ---------------------------------------------------------------------------
interface id_ex_pipe_reg_if #(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int ALUOP_W = 3
);
    logic               stall_i;
    logic               flush_i;
    logic               valid_i;
    logic [DATA_W-1:0]  pc4_i;
    logic [DATA_W-1:0]  rs_data_i;
    logic [DATA_W-1:0]  rt_data_i;
    logic [DATA_W-1:0]  imm_i;
    logic [REG_AW-1:0]  rs_i;
    logic [REG_AW-1:0]  rt_i;
    logic [REG_AW-1:0]  rd_i;
    logic [4:0]         shamt_i;
    logic [5:0]         funct_i;
    logic               reg_write_i;
    logic               mem_to_reg_i;
    logic               mem_read_i;
    logic               mem_write_i;
    logic               branch_i;
    logic               alu_src_i;
    logic               reg_dst_i;
    logic [ALUOP_W-1:0] alu_op_i;

    logic               valid_o;
    logic [DATA_W-1:0]  pc4_o;
    logic [DATA_W-1:0]  rs_data_o;
    logic [DATA_W-1:0]  rt_data_o;
    logic [DATA_W-1:0]  imm_o;
    logic [REG_AW-1:0]  rs_o;
    logic [REG_AW-1:0]  rt_o;
    logic [REG_AW-1:0]  rd_o;
    logic [4:0]         shamt_o;
    logic [5:0]         funct_o;
    logic               reg_write_o;
    logic               mem_to_reg_o;
    logic               mem_read_o;
    logic               mem_write_o;
    logic               branch_o;
    logic               alu_src_o;
    logic               reg_dst_o;
    logic [ALUOP_W-1:0] alu_op_o;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0]        bubble_cnt_o;
    logic [31:0]        stall_cnt_o;
`endif

    modport master (
        output stall_i, flush_i, valid_i, pc4_i, rs_data_i, rt_data_i, imm_i,
               rs_i, rt_i, rd_i, shamt_i, funct_i, reg_write_i, mem_to_reg_i,
               mem_read_i, mem_write_i, branch_i, alu_src_i, reg_dst_i, alu_op_i,
        input  valid_o, pc4_o, rs_data_o, rt_data_o, imm_o, rs_o, rt_o, rd_o,
               shamt_o, funct_o, reg_write_o, mem_to_reg_o, mem_read_o,
               mem_write_o, branch_o, alu_src_o, reg_dst_o, alu_op_o
`ifdef ID_EX_PERF_CNT_EN
        , input bubble_cnt_o, stall_cnt_o
`endif
    );

    modport slave (
        input  stall_i, flush_i, valid_i, pc4_i, rs_data_i, rt_data_i, imm_i,
               rs_i, rt_i, rd_i, shamt_i, funct_i, reg_write_i, mem_to_reg_i,
               mem_read_i, mem_write_i, branch_i, alu_src_i, reg_dst_i, alu_op_i,
        output valid_o, pc4_o, rs_data_o, rt_data_o, imm_o, rs_o, rt_o, rd_o,
               shamt_o, funct_o, reg_write_o, mem_to_reg_o, mem_read_o,
               mem_write_o, branch_o, alu_src_o, reg_dst_o, alu_op_o
`ifdef ID_EX_PERF_CNT_EN
        , output bubble_cnt_o, stall_cnt_o
`endif
    );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ---------------------------------------------------------------------------
// id_ex_pipe_reg
// ID/EX pipeline register of the 5-stage MIPS datapath. Captures decode
// outputs each rising edge of clk_i, holds them on stall, replaces them
// with an all-zero bubble on flush, and tracks a valid bit for EX/MEM/WB.
//
// Ports:
//   clk_i   clock, rising edge
//   rst_i   asynchronous, active-high reset (all outputs to 0)
//   bus     id_ex_pipe_reg_if.slave: hazard controls, decode inputs,
//           registered outputs to EX (and perf counters when enabled)
//
// Per-cycle mode:
//   mode   | meaning
//   LOAD   | capture inputs; controls gated to 0 when valid_i=0
//   HOLD   | stall: every output keeps its value
//   BUBBLE | flush: every output loads 0 (flush beats stall)
//
// Optional macro: ID_EX_PERF_CNT_EN adds saturating 32-bit bubble/stall
// counters driven onto bus.bubble_cnt_o / bus.stall_cnt_o.
// ---------------------------------------------------------------------------
module id_ex_pipe_reg #(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int ALUOP_W = 3
) (
    input  logic            clk_i,
    input  logic            rst_i,
    id_ex_pipe_reg_if.slave bus
);

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        HOLD   = 2'd1,
        BUBBLE = 2'd2
    } mode_e;

    mode_e mode;
    logic  ctrl_en;

    always_comb begin
        mode = LOAD;
        if (bus.flush_i) begin
            mode = BUBBLE;
        end else if (bus.stall_i) begin
            mode = HOLD;
        end
    end

    // An invalid slot still carries its data fields, but must never
    // write registers or memory, so its controls are forced low.
    assign ctrl_en = bus.valid_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bus.valid_o      <= 1'b0;
            bus.pc4_o        <= {DATA_W{1'b0}};
            bus.rs_data_o    <= {DATA_W{1'b0}};
            bus.rt_data_o    <= {DATA_W{1'b0}};
            bus.imm_o        <= {DATA_W{1'b0}};
            bus.rs_o         <= {REG_AW{1'b0}};
            bus.rt_o         <= {REG_AW{1'b0}};
            bus.rd_o         <= {REG_AW{1'b0}};
            bus.shamt_o      <= 5'd0;
            bus.funct_o      <= 6'd0;
            bus.reg_write_o  <= 1'b0;
            bus.mem_to_reg_o <= 1'b0;
            bus.mem_read_o   <= 1'b0;
            bus.mem_write_o  <= 1'b0;
            bus.branch_o     <= 1'b0;
            bus.alu_src_o    <= 1'b0;
            bus.reg_dst_o    <= 1'b0;
            bus.alu_op_o     <= {ALUOP_W{1'b0}};
        end else begin
            case (mode)
                LOAD: begin
                    bus.valid_o      <= bus.valid_i;
                    bus.pc4_o        <= bus.pc4_i;
                    bus.rs_data_o    <= bus.rs_data_i;
                    bus.rt_data_o    <= bus.rt_data_i;
                    bus.imm_o        <= bus.imm_i;
                    bus.rs_o         <= bus.rs_i;
                    bus.rt_o         <= bus.rt_i;
                    bus.rd_o         <= bus.rd_i;
                    bus.shamt_o      <= bus.shamt_i;
                    bus.funct_o      <= bus.funct_i;
                    bus.reg_write_o  <= bus.reg_write_i  & ctrl_en;
                    bus.mem_to_reg_o <= bus.mem_to_reg_i & ctrl_en;
                    bus.mem_read_o   <= bus.mem_read_i   & ctrl_en;
                    bus.mem_write_o  <= bus.mem_write_i  & ctrl_en;
                    bus.branch_o     <= bus.branch_i     & ctrl_en;
                    bus.alu_src_o    <= bus.alu_src_i    & ctrl_en;
                    bus.reg_dst_o    <= bus.reg_dst_i    & ctrl_en;
                    bus.alu_op_o     <= ctrl_en ? bus.alu_op_i : {ALUOP_W{1'b0}};
                end
                BUBBLE: begin
                    bus.valid_o      <= 1'b0;
                    bus.pc4_o        <= {DATA_W{1'b0}};
                    bus.rs_data_o    <= {DATA_W{1'b0}};
                    bus.rt_data_o    <= {DATA_W{1'b0}};
                    bus.imm_o        <= {DATA_W{1'b0}};
                    bus.rs_o         <= {REG_AW{1'b0}};
                    bus.rt_o         <= {REG_AW{1'b0}};
                    bus.rd_o         <= {REG_AW{1'b0}};
                    bus.shamt_o      <= 5'd0;
                    bus.funct_o      <= 6'd0;
                    bus.reg_write_o  <= 1'b0;
                    bus.mem_to_reg_o <= 1'b0;
                    bus.mem_read_o   <= 1'b0;
                    bus.mem_write_o  <= 1'b0;
                    bus.branch_o     <= 1'b0;
                    bus.alu_src_o    <= 1'b0;
                    bus.reg_dst_o    <= 1'b0;
                    bus.alu_op_o     <= {ALUOP_W{1'b0}};
                end
                HOLD: begin
                end
                default: begin
                end
            endcase
        end
    end

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] bubble_cnt_q;
    logic [31:0] stall_cnt_q;
    logic        bubble_inc;
    logic        stall_inc;

    // A bubble is either an explicit flush or an invalid slot being loaded.
    assign bubble_inc = (mode == BUBBLE) || ((mode == LOAD) && !bus.valid_i);
    assign stall_inc  = (mode == HOLD);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bubble_cnt_q <= 32'd0;
            stall_cnt_q  <= 32'd0;
        end else begin
            if (bubble_inc && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end
            if (stall_inc && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign bus.bubble_cnt_o = bubble_cnt_q;
    assign bus.stall_cnt_o  = stall_cnt_q;
`endif

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
- ID/EX pipeline register of the 5-stage MIPS datapath.
- Captures decode-stage outputs each clock and presents them to EX: the 32-bit sign-extended immediate, register-file read data, register addresses, instruction fields and control bits.
- Supports stall (hold contents) and flush (insert bubble), both driven by the hazard unit.
- Tracks a valid bit so EX/MEM/WB can tell real instructions from bubbles.

Parameters:
- DATA_W, 32, width of PC+4, register data and extended immediate
- REG_AW, 5, register address width
- ALUOP_W, 3, width of ALU op control field

Ports:
- clk_i  input  1  clock, rising edge
- rst_i  input  1  asynchronous, active-high reset
- stall_i  input  1  hold current contents (load-use hazard)
- flush_i  input  1  replace captured stage with bubble (branch taken / load-use bubble)
- valid_i  input  1  ID stage holds a real instruction
- pc4_i  input  DATA_W  PC+4 from IF/ID
- rs_data_i  input  DATA_W  register file read port 1
- rt_data_i  input  DATA_W  register file read port 2
- imm_i  input  DATA_W  sign-extended immediate
- rs_i, rt_i, rd_i  input  REG_AW each  instruction fields [25:21], [20:16], [15:11]
- shamt_i  input  5  instruction[10:6]
- funct_i  input  6  instruction[5:0]
- reg_write_i, mem_to_reg_i, mem_read_i, mem_write_i, branch_i, alu_src_i, reg_dst_i  input  1 each  decoder control bits
- alu_op_i  input  ALUOP_W  decoder ALU op
- Outputs: every *_i above (except stall_i, flush_i) as the registered *_o of equal width
- bubble_cnt_o, stall_cnt_o  output  32 each  present only with the optional feature

Behaviour:
- Reset (rst_i=1, asynchronous, any time): all outputs 0, including valid_o and all control bits. Reset mid-stall or mid-flush also forces 0. Outputs stay 0 until the first rising edge after rst_i deasserts.
- Latency: 1 cycle. Inputs sampled at edge N appear on outputs after edge N until next update.
- Normal (stall_i=0, flush_i=0): all fields load from inputs. valid_o<=valid_i.
- Stall (stall_i=1, flush_i=0): every output holds its value, data and control alike.
- Flush (flush_i=1): control bits (reg_write, mem_to_reg, mem_read, mem_write, branch, alu_src, reg_dst, alu_op) and valid_o load 0. Data/address fields (pc4, rs_data, rt_data, imm, rs, rt, rd, shamt, funct) also load 0, giving a clean NOP bubble.
- Simultaneous flush_i=1 and stall_i=1: flush wins; a bubble is inserted.
- valid_i=0 with no stall/flush: fields load normally. Control bits are gated to 0 so an invalid slot never writes memory or registers.
- No combinational path from any input to any output.
- State summary (per cycle): LOAD | HOLD | BUBBLE, chosen as: flush ? BUBBLE : stall ? HOLD : LOAD.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- Defined:
  - bubble_cnt_o increments on every edge where flush_i=1, or where LOAD occurs with valid_i=0.
  - stall_cnt_o increments on every edge with stall_i=1 and flush_i=0.
  - Both counters are 32-bit, saturate at 0xFFFFFFFF, and reset asynchronously to 0.
- Undefined: both ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset: assert rst_i mid-cycle while outputs hold non-zero data -> all outputs 0 immediately, without waiting for a clock edge.
- Load: valid_i=1, imm_i=0xFFFF8000, rs_data_i=0x12345678, reg_write_i=1, alu_op_i=3'b010, one edge -> imm_o=0xFFFF8000, rs_data_o=0x12345678, reg_write_o=1, alu_op_o=3'b010, valid_o=1.
- Stall: after the load, change inputs to imm_i=0x00000004 with stall_i=1 for 3 edges -> outputs unchanged (imm_o=0xFFFF8000). Release stall -> imm_o=0x00000004 after next edge.
- Flush: valid_i=1, mem_write_i=1, flush_i=1 -> after edge valid_o=0, mem_write_o=0, imm_o=0.
- Priority and gating:
  - stall_i=1 and flush_i=1 together -> bubble (valid_o=0).
  - valid_i=0 with reg_write_i=1, no stall/flush -> reg_write_o=0.
- Perf counters (ID_EX_PERF_CNT_EN): 4 stall cycles then 2 flush cycles -> stall_cnt_o=4, bubble_cnt_o=2. Counter preloaded via force to 0xFFFFFFFF, then a stall -> stays 0xFFFFFFFF.
